// File: rtl/lebug_pkg.sv
// Shared types and helpers for the trace-path stages.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lebug_pkg;

  localparam logic [7:0] CONFIG_ID_DATA_PACKER = 8'd0;
  localparam int         LANE_WIDTH            = 32;

  typedef logic [LANE_WIDTH-1:0] lane_t;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } pack_state_e;

  // A firmware size of 0, or one larger than the vector, means "keep every lane".
  function automatic logic [7:0] eff_size(input logic [7:0] size8, input int n);
    if (size8 == 8'd0 || int'(size8) > n) return 8'(n);
    return size8;
  endfunction

endpackage

// File: rtl/firmware_cfg_regs.sv
// Per-chain firmware registers (COMMIT, SIZE) loaded over the config byte bus.
// Latency: a byte is visible on the outputs the cycle after it is written.
// Backpressure: none; one byte is consumed per cycle while enabled and addressed.
module firmware_cfg_regs #(
  parameter int                           MAX_CHAINS         = 4,
  parameter logic [7:0]                   PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [MAX_CHAINS-1:0][7:0]   INITIAL_COMMIT     = '0,
  parameter logic [MAX_CHAINS-1:0][7:0]   INITIAL_SIZE       = '0
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           cfg_en_i,
  input  logic [7:0]                     config_id_i,
  input  logic [7:0]                     config_data_i,
  output logic [MAX_CHAINS-1:0][7:0]     commit_o,
  output logic [MAX_CHAINS-1:0][7:0]     size_o
);

  localparam int CHAIN_W = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  localparam int CNT_W   = $clog2(2 * MAX_CHAINS + 1);
  localparam logic [CNT_W-1:0] NCH  = CNT_W'(MAX_CHAINS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * MAX_CHAINS);

  logic [MAX_CHAINS-1:0][7:0] commit_q, commit_d;
  logic [MAX_CHAINS-1:0][7:0] size_q, size_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d, size_k;

  // Byte k goes to COMMIT[k], then SIZE[k-MAX_CHAINS]; the counter saturates so extra bytes are dropped.
  always_comb begin
    commit_d = commit_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    size_k   = cnt_q - NCH;
    if (cfg_en_i) begin
      if (config_id_i == PERSONAL_CONFIG_ID) begin
        if (cnt_q < NCH) begin
          commit_d[cnt_q[CHAIN_W-1:0]] = config_data_i;
        end else if (cnt_q < LAST) begin
          size_d[size_k[CHAIN_W-1:0]] = config_data_i;
        end
        if (cnt_q < LAST) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Register file with reload of the build-time firmware on reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      commit_q <= INITIAL_COMMIT;
      size_q   <= INITIAL_SIZE;
      cnt_q    <= '0;
    end else begin
      commit_q <= commit_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
    end
  end

  assign commit_o = commit_q;
  assign size_o   = size_q;

endmodule

// File: rtl/data_packer_stage.sv
// Keeps the first SIZE lanes of committed ALU vectors and packs them into dense N-lane words.
// Latency: 1 clk from the accepting edge to valid_out (a flush remainder follows one cycle later).
// Backpressure: none; downstream must take every valid_out pulse.
module data_packer_stage
  import lebug_pkg::*;
#(
  parameter int                          N                       = 8,
  parameter int                          DATA_WIDTH              = 32,
  parameter int                          MAX_CHAINS              = 4,
  parameter logic [7:0]                  PERSONAL_CONFIG_ID      = CONFIG_ID_DATA_PACKER,
  parameter logic [MAX_CHAINS-1:0][7:0]  INITIAL_FIRMWARE_COMMIT = '0,
  parameter logic [MAX_CHAINS-1:0][7:0]  INITIAL_FIRMWARE_SIZE   = '0,
  localparam int                         CHAIN_W                 = $clog2(MAX_CHAINS),
  localparam int                         LANES_W                 = $clog2(N + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             tracing,
  input  logic                             valid_in,
  input  logic [1:0]                       eof_in,
  input  logic [CHAIN_W-1:0]               chainId_in,
  input  logic [7:0]                       configId,
  input  logic [7:0]                       configData,
  input  logic [N-1:0][DATA_WIDTH-1:0]     vector_in,
  output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
  output logic [LANES_W-1:0]               valid_lanes_out,
  output logic                             valid_out
);

  localparam int FILL_W = $clog2(2 * N);
  localparam logic [FILL_W-1:0]  N_F = FILL_W'(N);
  localparam logic [LANES_W-1:0] N_L = LANES_W'(N);

  logic [MAX_CHAINS-1:0][7:0] commit_w, size_w;

  firmware_cfg_regs #(
    .MAX_CHAINS         (MAX_CHAINS),
    .PERSONAL_CONFIG_ID (PERSONAL_CONFIG_ID),
    .INITIAL_COMMIT     (INITIAL_FIRMWARE_COMMIT),
    .INITIAL_SIZE       (INITIAL_FIRMWARE_SIZE)
  ) u_fw (
    .clk_i         (clk),
    .reset_i       (reset),
    .cfg_en_i      (!tracing),
    .config_id_i   (configId),
    .config_data_i (configData),
    .commit_o      (commit_w),
    .size_o        (size_w)
  );

  // Lanes above fill are always zero, so a flush word needs no extra masking.
  logic [2*N-1:0][DATA_WIDTH-1:0] buf_q, buf_d, merged;
  logic [FILL_W-1:0]              fill_q, fill_d, base, s_w, sum, idx;
  pack_state_e                    state_q, state_d;
  logic                           accept, commit_bit;
  logic [N-1:0][DATA_WIDTH-1:0]   vec_q, vec_d;
  logic [LANES_W-1:0]             lanes_q, lanes_d;
  logic                           vld_q, vld_d;
  logic                           unused_bits;

  assign unused_bits = ^{eof_in[0], commit_w, size_w};

  // Append the kept lanes at the write point; while a remainder is pending the new vector starts a fresh buffer.
  always_comb begin
    commit_bit = commit_w[chainId_in][0];
    s_w        = FILL_W'(eff_size(size_w[chainId_in], N));
    accept     = tracing && valid_in && commit_bit;
    base       = (state_q == ST_PENDING) ? '0 : fill_q;
    sum        = base + s_w;
    merged     = (state_q == ST_PENDING) ? '0 : buf_q;
    idx        = '0;
    for (int j = 0; j < N; j++) begin
      idx = base + FILL_W'(j);
      if (FILL_W'(j) < s_w) merged[idx] = vector_in[j];
    end
  end

  // Next-state: full-word emit, short flush, or remainder emit from the PENDING state.
  always_comb begin
    buf_d   = buf_q;
    fill_d  = fill_q;
    state_d = state_q;
    vec_d   = '0;
    lanes_d = '0;
    vld_d   = 1'b0;
    if (tracing) begin
      if (state_q == ST_PENDING) begin
        vec_d   = buf_q[N-1:0];
        lanes_d = LANES_W'(fill_q);
        vld_d   = 1'b1;
        if (accept) begin
          buf_d   = merged;
          fill_d  = s_w;
          // A full vector or another frame end still needs its own emit slot.
          state_d = (s_w == N_F || eof_in[1]) ? ST_PENDING : ST_IDLE;
        end else begin
          buf_d   = '0;
          fill_d  = '0;
          state_d = ST_IDLE;
        end
      end else if (accept) begin
        if (sum >= N_F) begin
          vec_d          = merged[N-1:0];
          lanes_d        = N_L;
          vld_d          = 1'b1;
          buf_d          = '0;
          buf_d[N-1:0]   = merged[2*N-1:N];
          fill_d         = sum - N_F;
          if (eof_in[1] && sum != N_F) state_d = ST_PENDING;
        end else if (eof_in[1]) begin
          vec_d   = merged[N-1:0];
          lanes_d = LANES_W'(sum);
          vld_d   = 1'b1;
          buf_d   = '0;
          fill_d  = '0;
        end else begin
          buf_d  = merged;
          fill_d = sum;
        end
      end
    end
  end

  // Packing state and registered output word; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q   <= '0;
      fill_q  <= '0;
      state_q <= ST_IDLE;
      vec_q   <= '0;
      lanes_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      vec_q   <= vec_d;
      lanes_q <= lanes_d;
      vld_q   <= vld_d;
    end
  end

  assign vector_out      = vec_q;
  assign valid_lanes_out = lanes_q;
  assign valid_out       = vld_q;

endmodule

// File: tb/tb_data_packer_stage.sv
// Directed table-driven bench for data_packer_stage.
// Lane data encodes {vector id, lane} so packed words can be written as byte codes.
// Expected words are hand-computed in the tables below.
module tb_data_packer_stage;
  import lebug_pkg::*;

  localparam int N  = 8;
  localparam int DW = 32;

  logic               clk = 1'b0;
  logic               reset, tracing, valid_in;
  logic [1:0]         eof_in;
  logic [1:0]         chainId_in;
  logic [7:0]         configId, configData;
  logic [N-1:0][DW-1:0] vector_in, vector_out;
  logic [3:0]         valid_lanes_out;
  logic               valid_out;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string       name;
    logic        vin;
    logic        eof;
    logic [1:0]  chain;
    logic [7:0]  id;
    logic        exp_vld;
    logic [3:0]  exp_lanes;
    logic [63:0] exp_codes;
  } row_t;

  row_t       tab[$];
  logic [7:0] cfg_bytes[$];

  data_packer_stage #(
    .N                       (N),
    .DATA_WIDTH              (DW),
    .MAX_CHAINS              (4),
    .PERSONAL_CONFIG_ID      (CONFIG_ID_DATA_PACKER),
    .INITIAL_FIRMWARE_COMMIT ({8'd0, 8'd0, 8'd0, 8'd1}),
    .INITIAL_FIRMWARE_SIZE   ({8'd0, 8'd0, 8'd0, 8'd0})
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .tracing         (tracing),
    .valid_in        (valid_in),
    .eof_in          (eof_in),
    .chainId_in      (chainId_in),
    .configId        (configId),
    .configData      (configData),
    .vector_in       (vector_in),
    .vector_out      (vector_out),
    .valid_lanes_out (valid_lanes_out),
    .valid_out       (valid_out)
  );

  always #5 clk = ~clk;

  function automatic lane_t in_lane(input logic [7:0] id, input int j);
    return 32'hDA00_0000 | 32'({id[3:0], 4'(j)});
  endfunction

  function automatic logic [255:0] vec_of(input logic [63:0] codes);
    logic [N-1:0][DW-1:0] v;
    logic [7:0] c;
    for (int j = 0; j < N; j++) begin
      c    = codes[j*8 +: 8];
      v[j] = (c == 8'd0) ? 32'd0 : (32'hDA00_0000 | 32'(c));
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input string nm, input logic vin, input logic eof, input logic [1:0] ch,
                     input logic [7:0] id, input logic ev, input logic [3:0] el, input logic [63:0] ec);
    row_t r;
    r.name = nm; r.vin = vin; r.eof = eof; r.chain = ch; r.id = id;
    r.exp_vld = ev; r.exp_lanes = el; r.exp_codes = ec;
    tab.push_back(r);
  endtask

  task automatic run_table();
    foreach (tab[i]) begin
      @(negedge clk);
      valid_in   = tab[i].vin;
      eof_in     = {tab[i].eof, 1'b0};
      chainId_in = tab[i].chain;
      for (int j = 0; j < N; j++) vector_in[j] = in_lane(tab[i].id, j);
      @(posedge clk);
      #1;
      check($sformatf("%s.vld", tab[i].name), 256'(valid_out), 256'(tab[i].exp_vld));
      if (tab[i].exp_vld) begin
        check($sformatf("%s.lanes", tab[i].name), 256'(valid_lanes_out), 256'(tab[i].exp_lanes));
        check($sformatf("%s.vec", tab[i].name), vector_out, vec_of(tab[i].exp_codes));
      end
    end
    @(negedge clk);
    valid_in = 1'b0;
    eof_in   = 2'b00;
    tab.delete();
  endtask

  // Config bytes are written with a committed vector on the input; nothing may come out.
  task automatic cfg_load();
    foreach (cfg_bytes[k]) begin
      @(negedge clk);
      tracing    = 1'b0;
      valid_in   = 1'b1;
      eof_in     = 2'b10;
      chainId_in = 2'd0;
      configId   = CONFIG_ID_DATA_PACKER;
      configData = cfg_bytes[k];
      for (int j = 0; j < N; j++) vector_in[j] = in_lane(8'd14, j);
      @(posedge clk);
      #1;
      check($sformatf("cfg_quiet%0d", k), 256'(valid_out), 256'(0));
    end
    @(negedge clk);
    configId   = 8'hFF;
    configData = 8'h00;
    valid_in   = 1'b0;
    eof_in     = 2'b00;
    @(negedge clk);
    tracing = 1'b1;
  endtask

  initial begin
    reset = 1'b1; tracing = 1'b1; valid_in = 1'b0; eof_in = 2'b00; chainId_in = 2'd0;
    configId = 8'hFF; configData = 8'h00; vector_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.vld", 256'(valid_out), 256'(0));
    check("rst.lanes", 256'(valid_lanes_out), 256'(0));
    check("rst.vec", vector_out, 256'(0));
    @(negedge clk);
    reset = 1'b0;

    // Initial firmware: chain0 committed, SIZE 0 -> full vectors, one word per input.
    add("t1a", 1, 0, 0, 8'd1, 1, 4'd8, 64'h17_16_15_14_13_12_11_10);
    add("t1b", 1, 0, 0, 8'd2, 1, 4'd8, 64'h27_26_25_24_23_22_21_20);
    add("t1c", 1, 0, 0, 8'd3, 1, 4'd8, 64'h37_36_35_34_33_32_31_30);
    add("t1idle", 0, 0, 0, 8'd0, 0, 4'd0, 64'h0);
    run_table();

    // COMMIT={1,0,1,1}, SIZE={3,0,200,8}.
    cfg_bytes = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd3, 8'd0, 8'd200, 8'd8};
    cfg_load();

    add("t2a", 1, 0, 0, 8'd4, 0, 4'd0, 64'h0);
    add("t2b", 1, 0, 0, 8'd5, 0, 4'd0, 64'h0);
    add("t2c", 1, 0, 0, 8'd6, 1, 4'd8, 64'h61_60_52_51_50_42_41_40);
    add("uncommit", 1, 0, 1, 8'd8, 0, 4'd0, 64'h0);
    add("t2eof", 1, 1, 3, 8'd7, 1, 4'd8, 64'h76_75_74_73_72_71_70_62);
    add("t2rem", 0, 0, 0, 8'd0, 1, 4'd1, 64'h00_00_00_00_00_00_00_77);
    add("t3a", 1, 0, 0, 8'd9, 0, 4'd0, 64'h0);
    add("t3b", 1, 0, 0, 8'd10, 0, 4'd0, 64'h0);
    add("t3c_eof", 1, 1, 0, 8'd11, 1, 4'd8, 64'hB1_B0_A2_A1_A0_92_91_90);
    add("t3d_rem", 1, 0, 0, 8'd12, 1, 4'd1, 64'h00_00_00_00_00_00_00_B2);
    add("t3e_sz200", 1, 0, 2, 8'd13, 1, 4'd8, 64'hD4_D3_D2_D1_D0_C2_C1_C0);
    add("t3f_flush", 1, 1, 0, 8'd14, 1, 4'd6, 64'h00_00_E2_E1_E0_D7_D6_D5);
    add("t3g_exact", 1, 1, 2, 8'd15, 1, 4'd8, 64'hF7_F6_F5_F4_F3_F2_F1_F0);
    add("t3idle", 0, 0, 0, 8'd0, 0, 4'd0, 64'h0);
    run_table();

    // COMMIT={1,0,1,1}, SIZE={2,0,4,8}; the ninth byte must be dropped.
    cfg_bytes = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd2, 8'd0, 8'd4, 8'd8, 8'd0};
    cfg_load();

    add("t4ch1", 1, 0, 1, 8'd1, 0, 4'd0, 64'h0);
    add("t4a", 1, 0, 0, 8'd2, 0, 4'd0, 64'h0);
    add("t4b", 1, 0, 2, 8'd3, 0, 4'd0, 64'h0);
    add("t4c_eof", 1, 1, 0, 8'd4, 1, 4'd8, 64'h41_40_33_32_31_30_21_20);
    add("t4d", 1, 0, 3, 8'd5, 1, 4'd8, 64'h57_56_55_54_53_52_51_50);
    add("t4idle", 0, 0, 0, 8'd0, 0, 4'd0, 64'h0);
    run_table();

    // chain0 SIZE=5 to leave a partial buffer, then reset mid-frame.
    cfg_bytes = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd5, 8'd0, 8'd0, 8'd0};
    cfg_load();
    add("t5fill5", 1, 0, 0, 8'd1, 0, 4'd0, 64'h0);
    run_table();

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t5rst.vld", 256'(valid_out), 256'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("t5post.vld", 256'(valid_out), 256'(0));

    // Firmware reloaded (chain0 SIZE -> N) and the old partial lanes are gone.
    add("t5clean", 1, 0, 0, 8'd2, 1, 4'd8, 64'h27_26_25_24_23_22_21_20);
    add("t5idle", 0, 0, 0, 8'd0, 0, 4'd0, 64'h0);
    run_table();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
